// File: rtl/multi_dataflow_tcdm_responder.sv
// TCDM slave bank shared by NP master ports.
// A single-ported, word-wide memory serves one access per cycle. A round-robin
// arbiter picks the winner, and the response arrives one cycle after the grant.
// An optional periodic stall withholds every grant on one cycle in each
// STALL_PERIOD cycles, to exercise requester backpressure.
//
// Handshake (req/gnt, then r_valid): a master raises req together with add,
// wen, be and data, and holds all of them stable until it sees gnt=1 in the
// same cycle. gnt is combinational from req. The transfer happens at the
// rising edge that closes a cycle with req=1 and gnt=1. Exactly one cycle
// later that port sees r_valid=1, for reads and for writes. r_valid cannot be
// backpressured.
module multi_dataflow_tcdm_responder #(
  parameter int unsigned NP           = 3,
  parameter int unsigned NB_WORDS     = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter int unsigned STALL_PERIOD = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic [NP-1:0]        tcdm_req,
  output logic [NP-1:0]        tcdm_gnt,
  input  logic [NP-1:0][31:0]  tcdm_add,
  input  logic [NP-1:0]        tcdm_wen,
  input  logic [NP-1:0][3:0]   tcdm_be,
  input  logic [NP-1:0][31:0]  tcdm_data,
  output logic [NP-1:0][31:0]  tcdm_r_data,
  output logic [NP-1:0]        tcdm_r_valid,
  output logic [15:0]          err_cnt_o
);

  localparam int unsigned PW = (NP > 1) ? $clog2(NP) : 1;
  localparam int unsigned AW = (NB_WORDS > 1) ? $clog2(NB_WORDS) : 1;
  localparam int unsigned SW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

  localparam logic [PW-1:0] LAST_PORT  = PW'(NP - 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_PERIOD - 1);
  // One past the last byte of the bank. This is computed in 33 bits, so a
  // bank that ends at the top of the address space does not wrap.
  localparam logic [32:0]   ADDR_END   = {1'b0, BASE_ADDR} + (33'(NB_WORDS) << 2);
  localparam logic [31:0]   DEAD_WORD  = 32'hDEAD_BEEF;

  // Arbitration, stall and error state
  logic [PW-1:0] rr_ptr;
  logic [SW-1:0] stall_cnt;
  logic [15:0]   err_cnt;

  // Current-cycle decisions
  logic          stall_cycle;
  logic          found;
  logic          grant;
  logic [PW-1:0] win;
  logic [PW-1:0] cand;

  // Request selected by the arbiter
  logic [31:0]   sel_add;
  logic [31:0]   sel_data;
  logic [3:0]    sel_be;
  logic          sel_wen;
  logic          in_range;
  logic [AW-1:0] word_idx;
  logic          do_write;
  logic [31:0]   rdata_next;

  // Storage, not reset
  logic [31:0]   mem [NB_WORDS];

  // Registered response, one entry because only one access runs per cycle
  logic          resp_valid;
  logic [PW-1:0] resp_port;
  logic [31:0]   resp_data;

  // Stall cycle: the last count of every period (never when the period is 0)
  always_comb begin
    stall_cycle = 1'b0;
    if (STALL_PERIOD != 0) begin
      stall_cycle = (stall_cnt == STALL_LAST);
    end
  end

  // Round-robin search from rr_ptr, wrapping modulo NP; first requester wins
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 0; i < NP; i++) begin
      cand = PW'((int'(rr_ptr) + i) % NP);
      if (!found && tcdm_req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Grant the winner unless the cycle is a stall cycle or the bank is in reset
  always_comb begin
    grant    = found && !stall_cycle && rst_ni;
    tcdm_gnt = '0;
    if (grant) begin
      tcdm_gnt[win] = 1'b1;
    end
  end

  // Select the winning request and decode its address into a word index
  always_comb begin
    sel_add  = tcdm_add[win];
    sel_data = tcdm_data[win];
    sel_be   = tcdm_be[win];
    sel_wen  = tcdm_wen[win];
    in_range = ({1'b0, sel_add} >= {1'b0, BASE_ADDR}) && ({1'b0, sel_add} < ADDR_END);
    word_idx = AW'((sel_add - BASE_ADDR) >> 2);
    do_write = grant && !sel_wen && in_range;
  end

  // Read data for the response: stored word, the error pattern, or 0 for writes
  always_comb begin
    rdata_next = '0;
    if (grant && sel_wen) begin
      rdata_next = in_range ? mem[word_idx] : DEAD_WORD;
    end
  end

  // Byte-lane write at the granting edge. Out-of-range writes are dropped.
  always_ff @(posedge clk_i) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_be[b]) begin
          mem[word_idx][8*b +: 8] <= sel_data[8*b +: 8];
        end
      end
    end
  end

  // Response register. Reset drops a response that is still pending.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_valid <= 1'b0;
      resp_port  <= '0;
      resp_data  <= '0;
    end else begin
      resp_valid <= grant;
      resp_data  <= rdata_next;
      if (grant) begin
        resp_port <= win;
      end
    end
  end

  // Steer the response to the port that was granted. Other ports see zeros.
  always_comb begin
    tcdm_r_valid = '0;
    tcdm_r_data  = '0;
    for (int p = 0; p < NP; p++) begin
      if (resp_valid && (resp_port == PW'(p))) begin
        tcdm_r_valid[p] = 1'b1;
        tcdm_r_data[p]  = resp_data;
      end
    end
  end

  // Pointer moves past the winner on a grant. Clear wins over advance.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr <= '0;
    end else if (clear_i) begin
      rr_ptr <= '0;
    end else if (grant) begin
      rr_ptr <= (win == LAST_PORT) ? '0 : win + 1'b1;
    end
  end

  // Free-running stall counter, 0..STALL_PERIOD-1, independent of traffic
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt <= '0;
    end else if (clear_i) begin
      stall_cnt <= '0;
    end else if (STALL_PERIOD != 0) begin
      stall_cnt <= (stall_cnt == STALL_LAST) ? '0 : stall_cnt + 1'b1;
    end
  end

  // Saturating count of granted out-of-range accesses. Clear wins over increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt <= '0;
    end else if (clear_i) begin
      err_cnt <= '0;
    end else if (grant && !in_range && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end

  assign err_cnt_o = err_cnt;

endmodule

// File: tb/tb_multi_dataflow_tcdm_responder.sv
// Bench for multi_dataflow_tcdm_responder. It drives two instances: one with
// no stall, and one with STALL_PERIOD=4. Both instances share the same reset.
module tb_multi_dataflow_tcdm_responder;

  localparam int          NP     = 3;
  localparam int          NBW    = 64;
  localparam logic [31:0] BASE   = 32'h1000_0000;
  localparam int          STALL1 = 4;

  typedef struct {
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] data;
  } txn_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]                  clear_s = '0;
  logic [1:0][NP-1:0]          req_s   = '0;
  logic [1:0][NP-1:0][31:0]    add_s   = '0;
  logic [1:0][NP-1:0]          wen_s   = '0;
  logic [1:0][NP-1:0][3:0]     be_s    = '0;
  logic [1:0][NP-1:0][31:0]    data_s  = '0;
  logic [1:0][NP-1:0]          gnt_o;
  logic [1:0][NP-1:0][31:0]    rdata_o;
  logic [1:0][NP-1:0]          rvalid_o;
  logic [1:0][15:0]            err_o;

  multi_dataflow_tcdm_responder #(.NP(NP), .NB_WORDS(NBW), .BASE_ADDR(BASE), .STALL_PERIOD(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear_s[0]),
    .tcdm_req(req_s[0]), .tcdm_gnt(gnt_o[0]), .tcdm_add(add_s[0]), .tcdm_wen(wen_s[0]),
    .tcdm_be(be_s[0]), .tcdm_data(data_s[0]), .tcdm_r_data(rdata_o[0]),
    .tcdm_r_valid(rvalid_o[0]), .err_cnt_o(err_o[0])
  );

  multi_dataflow_tcdm_responder #(.NP(NP), .NB_WORDS(NBW), .BASE_ADDR(BASE), .STALL_PERIOD(STALL1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear_s[1]),
    .tcdm_req(req_s[1]), .tcdm_gnt(gnt_o[1]), .tcdm_add(add_s[1]), .tcdm_wen(wen_s[1]),
    .tcdm_be(be_s[1]), .tcdm_data(data_s[1]), .tcdm_r_data(rdata_o[1]),
    .tcdm_r_valid(rvalid_o[1]), .err_cnt_o(err_o[1])
  );

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Masters: each port (index d*NP+p) has a transaction queue and a held slot.
  txn_t txq [2*NP][$];
  txn_t slot [2*NP];
  logic slot_act [2*NP] = '{default: 1'b0};
  logic gnt_seen [2*NP] = '{default: 1'b0};

  // Behavioural model of both banks
  logic [31:0] mmem [2][NBW];
  int          m_ptr [2];
  int          m_cyc [2];
  int          m_err [2];
  logic        m_pv [2];
  int          m_pport [2];
  logic [31:0] m_pdata [2];

  // Observation logs used by the directed checks
  int          gnt_log [2][$];
  int          cyc_log [2][$];
  logic [31:0] resp_log [2*NP][$];

  logic [31:0] oor_tab [5] = '{BASE - 32'd4, BASE + 32'd256, 32'h0, 32'hFFFF_FFFC, BASE + 32'd259};

  function automatic int first_set(input logic [NP-1:0] g);
    for (int i = 0; i < NP; i++) if (g[i]) return i;
    return -1;
  endfunction

  // ---------------- driver ----------------
  // Masters hold their request until the grant has been seen, then load the next.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2*NP; k++) begin
      if (slot_act[k] && gnt_seen[k]) slot_act[k] = 1'b0;
      if (!slot_act[k] && txq[k].size() > 0) begin
        slot[k]     = txq[k].pop_front();
        slot_act[k] = 1'b1;
      end
      req_s[k/NP][k%NP]  = slot_act[k];
      add_s[k/NP][k%NP]  = slot[k].add;
      wen_s[k/NP][k%NP]  = slot[k].wen;
      be_s[k/NP][k%NP]   = slot[k].be;
      data_s[k/NP][k%NP] = slot[k].data;
    end
  end

  // ---------------- model + compare (every cycle, both banks) ----------------
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int          per;
      int          win;
      int          c;
      int          idx;
      logic        stall;
      logic        inr;
      logic        ev;
      logic [NP-1:0] eg;
      longint      la;
      if (!rst_n) begin
        chk($sformatf("rst_gnt%0d", d), 32'(gnt_o[d]), 32'h0);
        chk($sformatf("rst_rvalid%0d", d), 32'(rvalid_o[d]), 32'h0);
        for (int p = 0; p < NP; p++) chk($sformatf("rst_rdata%0d_%0d", d, p), rdata_o[d][p], 32'h0);
        chk($sformatf("rst_err%0d", d), 32'(err_o[d]), 32'h0);
        m_ptr[d] = 0; m_cyc[d] = 0; m_err[d] = 0; m_pv[d] = 1'b0;
        for (int p = 0; p < NP; p++) gnt_seen[d*NP+p] = 1'b0;
      end else begin
        per   = (d == 0) ? 0 : STALL1;
        stall = (per > 0) && ((m_cyc[d] % per) == per - 1);
        win   = -1;
        if (!stall) begin
          for (int i = 0; i < NP; i++) begin
            c = (m_ptr[d] + i) % NP;
            if (win < 0 && req_s[d][c]) win = c;
          end
        end
        eg = '0;
        if (win >= 0) eg[win] = 1'b1;
        chk($sformatf("gnt%0d", d), 32'(gnt_o[d]), 32'(eg));
        for (int p = 0; p < NP; p++) begin
          ev = m_pv[d] && (m_pport[d] == p);
          chk($sformatf("rvalid%0d_%0d", d, p), 32'(rvalid_o[d][p]), 32'(ev));
          chk($sformatf("rdata%0d_%0d", d, p), rdata_o[d][p], ev ? m_pdata[d] : 32'h0);
          if (rvalid_o[d][p]) resp_log[d*NP+p].push_back(rdata_o[d][p]);
          gnt_seen[d*NP+p] = gnt_o[d][p];
        end
        chk($sformatf("err%0d", d), 32'(err_o[d]), 32'(m_err[d]));
        if (gnt_o[d] != '0) gnt_log[d].push_back(first_set(gnt_o[d]));
        cyc_log[d].push_back(first_set(gnt_o[d]));
        // advance the model by this cycle's edge
        if (win >= 0) begin
          la  = longint'(add_s[d][win]);
          inr = (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * NBW);
          idx = inr ? int'((la - longint'(BASE)) / 4) : 0;
          if (!wen_s[d][win]) begin
            if (inr) begin
              for (int b = 0; b < 4; b++)
                if (be_s[d][win][b]) mmem[d][idx][8*b +: 8] = data_s[d][win][8*b +: 8];
            end
            m_pdata[d] = 32'h0;
          end else begin
            m_pdata[d] = inr ? mmem[d][idx] : 32'hDEAD_BEEF;
          end
          if (!inr && m_err[d] < 65535) m_err[d]++;
          m_pv[d]    = 1'b1;
          m_pport[d] = win;
        end else begin
          m_pv[d] = 1'b0;
        end
        if (clear_s[d]) begin
          m_ptr[d] = 0; m_cyc[d] = 0; m_err[d] = 0;
        end else begin
          if (win >= 0) m_ptr[d] = (win + 1) % NP;
          m_cyc[d]++;
        end
      end
    end
  end

  // ---------------- helper tasks ----------------
  task automatic push(input int d, input int p, input logic [31:0] add, input logic wen,
                      input logic [3:0] be, input logic [31:0] data);
    txn_t t;
    t.add = add; t.wen = wen; t.be = be; t.data = data;
    txq[d*NP+p].push_back(t);
  endtask

  function automatic logic is_idle(input int d);
    for (int p = 0; p < NP; p++)
      if (txq[d*NP+p].size() != 0 || slot_act[d*NP+p]) return 1'b0;
    return !m_pv[d];
  endfunction

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    forever begin
      @(posedge clk);
      if (is_idle(d)) break;
      n++;
      if (n > 3000) begin
        total++; bad++;
        $display("FAIL wait_idle%0d timed out actual=busy required=idle", d);
        break;
      end
    end
  endtask

  task automatic wait_grants(input int d, input int n);
    int k;
    k = 0;
    while (gnt_log[d].size() < n) begin
      @(posedge clk);
      k++;
      if (k > 200) begin
        total++; bad++;
        $display("FAIL wait_grants%0d timed out actual=%0d required=%0d", d, gnt_log[d].size(), n);
        break;
      end
    end
  endtask

  task automatic clear_logs();
    for (int d = 0; d < 2; d++) begin
      gnt_log[d].delete();
      cyc_log[d].delete();
    end
    for (int k = 0; k < 2*NP; k++) resp_log[k].delete();
  endtask

  task automatic pulse_clear(input int d);
    @(posedge clk); #2 clear_s[d] = 1'b1;
    @(posedge clk); #2 clear_s[d] = 1'b0;
  endtask

  function automatic logic [31:0] rl(input int k, input int i);
    if (i < resp_log[k].size()) return resp_log[k][i];
    return 32'hBAD0_BAD0;
  endfunction

  function automatic int gl(input int d, input int i);
    if (i < gnt_log[d].size()) return gnt_log[d][i];
    return -2;
  endfunction

  function automatic int cl(input int d, input int i);
    if (i < cyc_log[d].size()) return cyc_log[d][i];
    return -2;
  endfunction

  // ---------------- main sequence ----------------
  int stall_pat [12] = '{0, 0, 0, -1, 0, 0, 0, -1, 0, 0, 0, -1};
  int rr_pat [6]     = '{0, 1, 2, 0, 1, 2};
  int ngr;

  initial begin
    txn_t t;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_gnt_lit", 32'(gnt_o), 32'h0);
    chk("reset_rvalid_lit", 32'(rvalid_o), 32'h0);
    chk("reset_err_lit", 32'(err_o), 32'h0);
    @(posedge clk); #2 rst_n = 1'b1;

    // fill both banks with a known pattern: word w = 5A00_0000 | w
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < NBW; w++)
        push(d, 0, BASE + 32'(w * 4), 1'b0, 4'hF, 32'h5A00_0000 | 32'(w));
    wait_idle(0);
    wait_idle(1);

    // single-port write then read
    #2 clear_logs();
    push(0, 0, BASE + 32'd8, 1'b0, 4'hF, 32'hA5A5_1234);
    push(0, 0, BASE + 32'd8, 1'b1, 4'h0, 32'h0);
    wait_idle(0);
    chk("wr_rd_nresp", 32'(resp_log[0].size()), 32'd2);
    chk("wr_resp_zero", rl(0, 0), 32'h0);
    chk("rd_data", rl(0, 1), 32'hA5A5_1234);
    chk("wr_rd_port", 32'(gl(0, 1)), 32'd0);

    // byte enables
    #2 clear_logs();
    push(0, 1, BASE + 32'd12, 1'b0, 4'hF, 32'hFFFF_FFFF);
    push(0, 1, BASE + 32'd12, 1'b0, 4'b0101, 32'h0000_0000);
    push(0, 1, BASE + 32'd12, 1'b1, 4'h0, 32'h0);
    wait_idle(0);
    chk("be_readback", rl(1, 2), 32'hFF00_FF00);

    // round robin: all ports reading continuously from pointer 0
    pulse_clear(0);
    clear_logs();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++)
        push(0, p, BASE + 32'(4 * (20 + p)), 1'b1, 4'hF, 32'h0);
    wait_idle(0);
    for (int i = 0; i < 6; i++) chk($sformatf("rr_order%0d", i), 32'(gl(0, i)), 32'(rr_pat[i]));
    chk("rr_data_p0", rl(0, 1), 32'h5A00_0014);
    chk("rr_data_p1", rl(1, 0), 32'h5A00_0015);
    chk("rr_data_p2", rl(2, 1), 32'h5A00_0016);

    // stall pattern on bank 1, right after reset, port 0 requesting every cycle
    @(posedge clk); #2 rst_n = 1'b0;
    clear_logs();
    for (int k = 0; k < 12; k++)
      push(1, 0, BASE + 32'(4 * (40 + k)), 1'b0, 4'hF, 32'hC0DE_0000 + 32'(k));
    @(posedge clk); #2 rst_n = 1'b1;
    wait_idle(1);
    ngr = 0;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("stall_cyc%0d", i), 32'(cl(1, i)), 32'(stall_pat[i]));
      if (cl(1, i) == 0) ngr++;
    end
    chk("stall_grants12", 32'(ngr), 32'd9);
    clear_logs();
    for (int k = 0; k < 12; k++) push(1, 0, BASE + 32'(4 * (40 + k)), 1'b1, 4'hF, 32'h0);
    wait_idle(1);
    for (int k = 0; k < 12; k++)
      chk($sformatf("stall_keep%0d", k), rl(NP, k), 32'hC0DE_0000 + 32'(k));

    // out-of-range accesses and clearing the error count
    pulse_clear(0);
    clear_logs();
    push(0, 2, BASE + 32'(4 * NBW), 1'b1, 4'hF, 32'h0);
    wait_idle(0);
    @(negedge clk); #1;
    chk("oor_rd_data", rl(2, 0), 32'hDEAD_BEEF);
    chk("oor_err1", 32'(err_o[0]), 32'd1);
    @(posedge clk); #2;
    push(0, 2, BASE - 32'd4, 1'b0, 4'hF, 32'h1234_5678);
    wait_idle(0);
    @(negedge clk); #1;
    chk("oor_err2", 32'(err_o[0]), 32'd2);
    @(posedge clk); #2 clear_logs();
    push(0, 2, BASE + 32'd252, 1'b1, 4'hF, 32'h0);
    push(0, 2, BASE, 1'b1, 4'hF, 32'h0);
    wait_idle(0);
    chk("oor_wr_dropped_hi", rl(2, 0), 32'h5A00_003F);
    chk("oor_wr_dropped_lo", rl(2, 1), 32'h5A00_0000);
    pulse_clear(0);
    @(negedge clk); #1;
    chk("oor_clear", 32'(err_o[0]), 32'd0);

    // reset in the response cycle of a read
    @(posedge clk); #2;
    push(0, 0, BASE + 32'd16, 1'b0, 4'hF, 32'h1357_9BDF);
    wait_idle(0);
    #2 clear_logs();
    push(0, 0, BASE + 32'd16, 1'b1, 4'hF, 32'h0);
    wait_grants(0, 1);
    #2 rst_n = 1'b0;
    @(negedge clk); #1;
    chk("rst_drop_rvalid", 32'(rvalid_o[0]), 32'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    chk("rst_drop_noresp", 32'(resp_log[0].size()), 32'd0);
    push(0, 0, BASE + 32'd16, 1'b1, 4'hF, 32'h0);
    wait_idle(0);
    chk("rst_mem_kept", rl(0, 0), 32'h1357_9BDF);

    // randomized traffic on both banks, with occasional clears
    @(posedge clk);
    repeat (400) begin
      @(posedge clk); #2;
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < NP; p++) begin
          if (txq[d*NP+p].size() < 3 && $urandom_range(0, 2) == 0) begin
            if ($urandom_range(0, 9) == 0) t.add = oor_tab[$urandom_range(0, 4)];
            else t.add = BASE + 32'($urandom_range(0, NBW - 1)) * 32'd4 + 32'($urandom_range(0, 3));
            t.wen  = 1'($urandom_range(0, 1));
            t.be   = 4'($urandom_range(0, 15));
            t.data = $urandom();
            txq[d*NP+p].push_back(t);
          end
        end
        clear_s[d] = ($urandom_range(0, 39) == 0);
      end
    end
    @(posedge clk); #2 clear_s = '0;
    wait_idle(0);
    wait_idle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
